// File: rtl/regfile_write_arbiter_if.sv
// Bundle of the register-file write-port signals shared by the in-order
// pipeline, the long-latency unit and the hazard unit. The arbiter sits on
// the slave side; whoever drives the writeback sources uses master.
//
// Handshake (lu_*): a result transfers on a rising clk edge where
// lu_valid && lu_ready are both 1. The source holds lu_write_addr and
// lu_write_data stable while lu_valid is high and not yet accepted.
// lu_ready never depends on lu_valid. A transfer to address 0 completes
// but is discarded.
interface regfile_write_arbiter_if #(
    parameter int AW = 2
);
    logic          pipe_RegWrite;
    logic [4:0]    pipe_write_addr;
    logic [31:0]   pipe_write_data;
    logic          lu_valid;
    logic          lu_ready;
    logic [4:0]    lu_write_addr;
    logic [31:0]   lu_write_data;
    logic          RegWrite;
    logic [4:0]    write_addr;
    logic [31:0]   write_data;
    logic [31:0]   pending;
    logic [AW:0]   count;
    logic          waw_conflict;

    modport master (
        output pipe_RegWrite, pipe_write_addr, pipe_write_data,
        output lu_valid, lu_write_addr, lu_write_data,
        input  lu_ready,
        input  RegWrite, write_addr, write_data,
        input  pending, count, waw_conflict
    );

    modport slave (
        input  pipe_RegWrite, pipe_write_addr, pipe_write_data,
        input  lu_valid, lu_write_addr, lu_write_data,
        output lu_ready,
        output RegWrite, write_addr, write_data,
        output pending, count, waw_conflict
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Single write port arbiter for the 31-entry register file. Pipeline
// writebacks always win; long-latency results queue in a small FIFO and
// drain in cycles where the pipeline leaves the write slot free.
module regfile_write_arbiter #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    regfile_write_arbiter_if.slave  bus
);
    localparam logic [AW:0]   FULL    = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [4:0]       addr_mem [DEPTH];
    logic [31:0]      data_mem [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [AW:0]      count_q;

    logic             pipe_slot;
    logic             ready;
    logic             push;
    logic             pop;
    logic [31:0]      pending_c;

    // Slot ownership and handshake qualifiers. Writes to $0 are non-writes.
    always_comb begin
        pipe_slot = bus.pipe_RegWrite && (bus.pipe_write_addr != 5'd0);
        ready     = !reset && (count_q < FULL);
        push      = bus.lu_valid && ready && (bus.lu_write_addr != 5'd0);
        pop       = !reset && !pipe_slot && (count_q != '0);
    end

    // Register-file write port: pipeline first, then FIFO head, else idle.
    always_comb begin
        bus.RegWrite   = 1'b0;
        bus.write_addr = 5'd0;
        bus.write_data = 32'd0;
        if (!reset) begin
            if (pipe_slot) begin
                bus.RegWrite   = 1'b1;
                bus.write_addr = bus.pipe_write_addr;
                bus.write_data = bus.pipe_write_data;
            end else if (count_q != '0) begin
                bus.RegWrite   = 1'b1;
                bus.write_addr = addr_mem[rd_ptr];
                bus.write_data = data_mem[rd_ptr];
            end
        end
    end

    // Pending map: OR of the destination decodes of every live entry.
    always_comb begin
        pending_c = 32'd0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i]) begin
                pending_c[addr_mem[i]] = 1'b1;
            end
        end
        pending_c[0] = 1'b0;
    end

    // Remaining outputs; waw_conflict flags a pipeline write that overtakes
    // a queued write to the same register (the write still happens).
    always_comb begin
        bus.lu_ready     = ready;
        bus.pending      = pending_c;
        bus.count        = count_q;
        bus.waw_conflict = !reset && pipe_slot && pending_c[bus.pipe_write_addr];
    end

    // FIFO control state: pointers, occupancy and per-entry valid bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            if (push) begin
                wr_ptr          <= wr_ptr + PTR_ONE;
                valid_q[wr_ptr] <= 1'b1;
            end
            if (pop) begin
                rd_ptr          <= rd_ptr + PTR_ONE;
                valid_q[rd_ptr] <= 1'b0;
            end
            if (push && !pop) begin
                count_q <= count_q + CNT_ONE;
            end else if (pop && !push) begin
                count_q <= count_q - CNT_ONE;
            end
        end
    end

    // FIFO payload storage; push is already blocked while reset is high.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr] <= bus.lu_write_addr;
            data_mem[wr_ptr] <= bus.lu_write_data;
        end
    end
endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Drives the single write port of the 31-entry general-purpose register file, i.e. its RegWrite, write_addr and write_data inputs.
- Merges two writeback sources:
  - the in-order pipeline writeback stage, which has absolute priority and is never stalled;
  - a long-latency unit (mul/div, load miss), which uses a valid/ready handshake and is buffered in a FIFO.
- Exports per-register pending bits so the hazard unit can stall readers of registers with queued writes.

Parameters:
- DEPTH, 4, FIFO entries for long-latency writebacks; power of two, at least 2.
- AW, 2, pointer width; equals log2(DEPTH).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- pipe_RegWrite  in  1  pipeline writeback request.
- pipe_write_addr  in  5  pipeline destination register.
- pipe_write_data  in  32  pipeline writeback data.
- lu_valid  in  1  long-latency result valid.
- lu_ready  out  1  FIFO can accept a result.
- lu_write_addr  in  5  long-latency destination register.
- lu_write_data  in  32  long-latency result data.
- RegWrite  out  1  register file write enable.
- write_addr  out  5  register file write address.
- write_data  out  32  register file write data.
- pending  out  32  bit i = 1 when a valid FIFO entry targets register i; bit 0 is always 0.
- count  out  AW+1  number of valid FIFO entries.
- waw_conflict  out  1  pipeline write targets a register that is pending in the FIFO.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Reset:
  - On a clk edge with reset=1: rd_ptr, wr_ptr and count clear to 0, and all entry valid bits clear.
  - Anything pushed in that cycle is dropped.
  - While reset=1 the outputs are forced: RegWrite=0, lu_ready=0, waw_conflict=0, write_addr=0, write_data=0.
  - After reset: pending=0, count=0, RegWrite=0.
- Slot use:
  - pipe_slot = pipe_RegWrite && pipe_write_addr != 0.
  - A pipeline write to $0 is treated as no write and leaves the slot free.
- Write port, purely combinational with 0-cycle latency from its inputs:
  - If pipe_slot: RegWrite=1, write_addr/write_data = pipeline inputs.
  - Else if count != 0: RegWrite=1, write_addr/write_data = FIFO head, and pop fires this cycle.
  - Else: RegWrite=0, write_addr=0, write_data=0.
- Handshake:
  - lu_ready = !reset && (count < DEPTH). It does not depend on same-cycle pop, so full means not ready even while draining.
  - push = lu_valid && lu_ready && lu_write_addr != 0.
  - A transfer with address 0 completes the handshake but is discarded and never enqueued.
- FIFO:
  - Strict FIFO ordering; pointers wrap modulo DEPTH.
  - Simultaneous push and pop leaves count unchanged; the head is written to the register file in the same cycle.
  - Push into an empty FIFO becomes the head on the next cycle. There is no same-cycle bypass to the write port.
- Starvation: queued entries drain only in cycles with pipe_slot=0. The pipeline must produce idle writeback slots, which is guaranteed by the hazard unit stalling on pending.
- pending:
  - Combinational OR of the address decodes of the valid entries.
  - Cleared for a register when its last queued entry pops, visible in the cycle after the pop.
- waw_conflict:
  - Asserted combinationally when pipe_slot && pending[pipe_write_addr].
  - The pipeline write still goes through; the arbiter never reorders or suppresses writes.
- Register file read side and forwarding are out of scope.

Test Plan:
- Reset then idle: assert reset for 2 cycles with lu_valid=1 -> lu_ready=0 and RegWrite=0 during reset; after release count=0, pending=0, and nothing was enqueued.
- Pipeline priority: FIFO holds {r5=0x11}; pipe writes r3=0xAA -> RegWrite=1, addr=3, data=0xAA. Next cycle with pipe idle -> addr=5, data=0x11, count goes 1 to 0, and pending[5] is 0 the cycle after.
- Fill to full: push r1..r4 (0x1..0x4) while the pipe writes r9 every cycle -> after 4 pushes count=4, lu_ready=0, pending=0x1E. Pipe goes idle -> drains r1, r2, r3, r4 in order, one per cycle.
- Push and pop same cycle: FIFO holds {r7}; pipe idle; push r8=0x88 -> r7 written, count stays 1. Next cycle r8 written, count=0.
- $0 handling: lu push to r0 -> handshake completes, count stays 0. pipe write to r0 with FIFO {r6=0x66} -> r6 drains that cycle.
- WAW and reset mid-operation: FIFO {r10}; pipe writes r10=0x5 -> waw_conflict=1 and the write is performed. Assert reset with count=3 -> next cycle count=0, pending=0, and no queued write reaches the port.
